// File: rtl/mem_wb_unit.sv
// Memory-access / write-back stage: fetches load data over a req/ack handshake
// (with a bounded wait), then issues a single register-file write and a done pulse.
module mem_wb_unit #(
  parameter int         ADDR_W    = 4,
  parameter int         DATA_W    = 8,
  parameter int         TIMEOUT   = 15,
  parameter logic [2:0] STATE_MEM = 3'd3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [2:0]        state,
  input  logic              valid,
  input  logic              write,
  input  logic              data_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_reg,
  input  logic [4:0]        dest_reg,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_REQ,
    S_WB,
    S_HOLD
  } fsm_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  fsm_t       r_fsm;
  logic [7:0] r_cnt;
  logic       r_wr_en;
  logic [4:0] r_dest;

  logic [4:0] w_dest;
  logic       w_cnt_last;

  assign w_dest     = (alu_reg != 5'd0) ? alu_reg : dest_reg;
  assign w_cnt_last = ((r_cnt + 8'd1) == TIMEOUT_CNT);

  // rf_we/done are registered on entry to WB so they are high for exactly the WB cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fsm       <= S_IDLE;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_dest      <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (state == STATE_MEM) begin
            if (valid && data_en) begin
              r_dest   <= w_dest;
              r_wr_en  <= write && (w_dest != 5'd0);
              mem_req  <= 1'b1;
              mem_addr <= data_addr;
              r_cnt    <= '0;
              r_fsm    <= S_MEM_REQ;
            end else begin
              rf_waddr <= w_dest;
              rf_wdata <= alu_result;
              rf_we    <= valid && write && (w_dest != 5'd0);
              done     <= 1'b1;
              r_fsm    <= S_WB;
            end
          end
        end
        S_MEM_REQ: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            rf_waddr <= r_dest;
            rf_wdata <= mem_rdata;
            rf_we    <= r_wr_en;
            done     <= 1'b1;
            r_fsm    <= S_WB;
          end else if (w_cnt_last) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            rf_waddr    <= r_dest;
            done        <= 1'b1;
            r_fsm       <= S_WB;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WB:    r_fsm <= S_HOLD;
        S_HOLD:  if (state != STATE_MEM) r_fsm <= S_IDLE;
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_unit.sv
// Bench for mem_wb_unit: scenario tasks drive instructions, push expected writes
// onto a scoreboard queue, and pop/compare when the stage pulses done.
module tb_mem_wb_unit;

  localparam int         ADDR_W  = 4;
  localparam int         DATA_W  = 8;
  localparam int         TIMEOUT = 15;
  localparam logic [2:0] ST_MEM  = 3'd3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [2:0]        state = 3'd0;
  logic              valid = 1'b0, write = 1'b0, data_en = 1'b0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] alu_result = '0;
  logic [4:0]        alu_reg = '0, dest_reg = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              done;
  logic              timeout_err;

  mem_wb_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STATE_MEM(ST_MEM)) dut (
    .clk(clk), .rstn(rstn), .state(state), .valid(valid), .write(write), .data_en(data_en),
    .data_addr(data_addr), .alu_result(alu_result), .alu_reg(alu_reg), .dest_reg(dest_reg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [7:0]  d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Memory model: acks on the ack_delay-th request cycle (0 = never acks).
  int         ack_delay = 0;
  logic [7:0] ack_data  = '0;
  logic       resp_ack  = 1'b0;
  logic       stray_ack = 1'b0;
  int         resp_cnt  = 0;
  assign mem_ack = resp_ack | stray_ack;

  always @(negedge clk) begin
    if (mem_req) begin
      if (ack_delay != 0 && resp_cnt + 1 == ack_delay) begin
        resp_ack  <= 1'b1;
        mem_rdata <= ack_data;
      end else begin
        resp_ack <= 1'b0;
      end
      resp_cnt <= resp_cnt + 1;
    end else begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one instruction; returns just after the trigger edge with the
  // non-state inputs scrambled, since the stage must ignore them from then on.
  task automatic issue(input logic v, input logic w, input logic de, input logic [3:0] addr,
                       input logic [7:0] res, input logic [4:0] areg, input logic [4:0] dreg);
    @(negedge clk);
    valid = v; write = w; data_en = de; data_addr = addr;
    alu_result = res; alu_reg = areg; dest_reg = dreg;
    state = ST_MEM;
    @(posedge clk);
    #1;
    valid = 1'($urandom); write = 1'($urandom); data_en = 1'($urandom);
    data_addr = 4'($urandom); alu_result = 8'($urandom);
    alu_reg = 5'($urandom); dest_reg = 5'($urandom);
  endtask

  // Collects DUT activity until done (bounded); performs no comparisons itself.
  task automatic wait_done(input int maxc, input logic [3:0] exp_addr, output logic got,
                           output int cyc, output int reqc, output logic maddr_bad,
                           output logic we, output logic [4:0] a, output logic [7:0] d);
    got = 1'b0; cyc = 0; reqc = 0; maddr_bad = 1'b0; we = 1'b0; a = '0; d = '0;
    while (!got && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        reqc++;
        if (mem_addr !== exp_addr) maddr_bad = 1'b1;
      end
      if (done === 1'b1) begin
        got = 1'b1; we = rf_we; a = rf_waddr; d = rf_wdata;
      end
    end
  endtask

  task automatic release_stage();
    state = 3'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    state = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, rf_we, done, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: req/we/done/terr=%b required 0000", {mem_req, rf_we, done, timeout_err});
    end
    checks++;
    if ({mem_addr, rf_waddr, rf_wdata} !== 17'd0) begin
      errors++;
      $display("FAIL reset_buses: addr=%h waddr=%0d wdata=%h required all 0", mem_addr, rf_waddr, rf_wdata);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addu();
    logic got, mb, we; int cyc, reqc, extra; logic [4:0] a; logic [7:0] d; exp_t e;
    exp_q.push_back('{we: 1'b1, a: 5'd5, d: 8'h2A});
    issue(1'b1, 1'b1, 1'b0, 4'h0, 8'h2A, 5'd0, 5'd5);
    wait_done(10, 4'h0, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || we !== e.we || (e.we && (a !== e.a || d !== e.d))) begin
      errors++;
      $display("FAIL addu_wb: done=%b we=%b waddr=%0d wdata=%h required done=1 we=%b waddr=%0d wdata=%h",
               got, we, a, d, e.we, e.a, e.d);
    end
    checks++;
    if (cyc !== 1 || reqc !== 0) begin
      errors++;
      $display("FAIL addu_latency: cycles=%0d req_cycles=%0d required 1 and 0", cyc, reqc);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || rf_we || mem_req) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL addu_no_retrigger: extra active cycles=%0d required 0", extra);
    end
    release_stage();
  endtask

  task automatic test_lw(input int delay, input logic [3:0] addr, input logic [7:0] rd,
                         input logic [4:0] dreg);
    logic got, mb, we; int cyc, reqc; logic [4:0] a; logic [7:0] d; exp_t e;
    ack_delay = delay; ack_data = rd;
    exp_q.push_back('{we: 1'b1, a: dreg, d: rd});
    issue(1'b1, 1'b1, 1'b1, addr, 8'h55, 5'd0, dreg);
    wait_done(30, addr, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || we !== e.we || (e.we && (a !== e.a || d !== e.d))) begin
      errors++;
      $display("FAIL lw_wb: done=%b we=%b waddr=%0d wdata=%h required done=1 we=%b waddr=%0d wdata=%h",
               got, we, a, d, e.we, e.a, e.d);
    end
    checks++;
    if (reqc !== delay || cyc !== delay + 1 || mb !== 1'b0) begin
      errors++;
      $display("FAIL lw_handshake: req_cycles=%0d done_cycle=%0d addr_bad=%b required %0d, %0d, 0",
               reqc, cyc, mb, delay, delay + 1);
    end
    release_stage();
  endtask

  task automatic test_jal();
    logic got, mb, we; int cyc, reqc; logic [4:0] a; logic [7:0] d; exp_t e;
    exp_q.push_back('{we: 1'b1, a: 5'd31, d: 8'h14});
    issue(1'b1, 1'b1, 1'b0, 4'h0, 8'h14, 5'd31, 5'd7);
    wait_done(10, 4'h0, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || cyc !== 1 || we !== e.we || a !== e.a || d !== e.d) begin
      errors++;
      $display("FAIL jal_wb: done=%b cyc=%0d we=%b waddr=%0d wdata=%h required 1 1 %b %0d %h",
               got, cyc, we, a, d, e.we, e.a, e.d);
    end
    release_stage();
  endtask

  task automatic test_suppressed();
    logic got, mb, we; int cyc, reqc; logic [4:0] a; logic [7:0] d;
    // valid=0, even with data_en set, must neither fetch nor write
    exp_q.push_back('{we: 1'b0, a: 5'd0, d: 8'h00});
    issue(1'b0, 1'b1, 1'b1, 4'h5, 8'hAA, 5'd0, 5'd6);
    wait_done(10, 4'h5, got, cyc, reqc, mb, we, a, d);
    void'(exp_q.pop_front());
    checks++;
    if (!got || cyc !== 1 || we !== 1'b0 || reqc !== 0) begin
      errors++;
      $display("FAIL invalid_suppress: done=%b cyc=%0d we=%b req_cycles=%0d required 1 1 0 0",
               got, cyc, we, reqc);
    end
    release_stage();
    exp_q.push_back('{we: 1'b0, a: 5'd0, d: 8'h00});
    issue(1'b1, 1'b1, 1'b0, 4'h0, 8'hBB, 5'd0, 5'd0);
    wait_done(10, 4'h0, got, cyc, reqc, mb, we, a, d);
    void'(exp_q.pop_front());
    checks++;
    if (!got || cyc !== 1 || we !== 1'b0) begin
      errors++;
      $display("FAIL r0_suppress: done=%b cyc=%0d we=%b required 1 1 0", got, cyc, we);
    end
    release_stage();
  endtask

  task automatic test_timeout();
    logic got, mb, we; int cyc, reqc, extra; logic [4:0] a; logic [7:0] d; exp_t e;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL terr_initial: timeout_err=%b required 0", timeout_err);
    end
    ack_delay = 0;
    exp_q.push_back('{we: 1'b0, a: 5'd0, d: 8'h00});
    issue(1'b1, 1'b1, 1'b1, 4'h2, 8'h77, 5'd0, 5'd9);
    wait_done(40, 4'h2, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || we !== e.we || reqc !== TIMEOUT || cyc !== TIMEOUT + 1 || mb !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abandon: done=%b we=%b req_cycles=%0d done_cycle=%0d addr_bad=%b required 1 0 %0d %0d 0",
               got, we, reqc, cyc, mb, TIMEOUT, TIMEOUT + 1);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: timeout_err=%b required 1", timeout_err);
    end
    release_stage();
    stray_ack = 1'b1;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || rf_we || mem_req) extra++;
    end
    stray_ack = 1'b0;
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL stray_ack_idle: active cycles=%0d required 0", extra);
    end
    exp_q.push_back('{we: 1'b1, a: 5'd4, d: 8'h11});
    issue(1'b1, 1'b1, 1'b0, 4'h0, 8'h11, 5'd0, 5'd4);
    wait_done(10, 4'h0, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || we !== e.we || a !== e.a || d !== e.d || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: done=%b we=%b waddr=%0d wdata=%h terr=%b required 1 1 %0d %h 1",
               got, we, a, d, timeout_err, e.a, e.d);
    end
    release_stage();
  endtask

  task automatic test_reset_mid_lw();
    logic got, mb, we; int cyc, reqc, extra; logic [4:0] a; logic [7:0] d; exp_t e;
    ack_delay = 0;
    issue(1'b1, 1'b1, 1'b1, 4'h6, 8'h99, 5'd0, 5'd8);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midlw_req: mem_req=%b required 1", mem_req);
    end
    @(negedge clk);
    rstn = 1'b0;
    state = 3'd0;
    @(negedge clk);
    checks++;
    if ({mem_req, done, rf_we, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL midlw_reset: req/done/we/terr=%b required 0000", {mem_req, done, rf_we, timeout_err});
    end
    rstn = 1'b1;
    stray_ack = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      stray_ack = 1'b0;
      if (done || rf_we || mem_req) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL midlw_late_ack: active cycles=%0d required 0", extra);
    end
    exp_q.push_back('{we: 1'b1, a: 5'd10, d: 8'h5A});
    issue(1'b1, 1'b1, 1'b0, 4'h0, 8'h5A, 5'd0, 5'd10);
    wait_done(10, 4'h0, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || cyc !== 1 || we !== e.we || a !== e.a || d !== e.d) begin
      errors++;
      $display("FAIL post_reset_wb: done=%b cyc=%0d we=%b waddr=%0d wdata=%h required 1 1 1 %0d %h",
               got, cyc, we, a, d, e.a, e.d);
    end
    release_stage();
  endtask

  task automatic test_back_to_back();
    logic got, mb, we; int cyc, reqc; logic [4:0] a; logic [7:0] d; exp_t e;
    ack_delay = 2; ack_data = 8'h3C;
    exp_q.push_back('{we: 1'b1, a: 5'd2, d: 8'h3C});
    exp_q.push_back('{we: 1'b1, a: 5'd6, d: 8'h66});
    issue(1'b1, 1'b1, 1'b1, 4'hE, 8'h01, 5'd0, 5'd2);
    wait_done(20, 4'hE, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || cyc !== 3 || we !== e.we || a !== e.a || d !== e.d) begin
      errors++;
      $display("FAIL b2b_first: done=%b cyc=%0d we=%b waddr=%0d wdata=%h required 1 3 1 %0d %h",
               got, cyc, we, a, d, e.a, e.d);
    end
    release_stage();
    issue(1'b1, 1'b1, 1'b0, 4'h0, 8'h66, 5'd0, 5'd6);
    wait_done(10, 4'h0, got, cyc, reqc, mb, we, a, d);
    e = exp_q.pop_front();
    checks++;
    if (!got || cyc !== 1 || we !== e.we || a !== e.a || d !== e.d) begin
      errors++;
      $display("FAIL b2b_second: done=%b cyc=%0d we=%b waddr=%0d wdata=%h required 1 1 1 %0d %h",
               got, cyc, we, a, d, e.a, e.d);
    end
    release_stage();
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw(3, 4'h9, 8'hC3, 5'd3);
    test_lw(1, 4'h4, 8'h7E, 5'd12);
    test_jal();
    test_suppressed();
    test_timeout();
    test_reset_mid_lw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
